// File: rtl/seq_adder_ctrl_pkg.sv
// Shared definitions for the sequential (chunked) adder controller.
//   state_e      : FSM state encoding (IDLE=0, CALC=1, DONE=2)
//   DEF_WIDTH    : default operand width
//   DEF_CHUNK    : default adder slice width
//   idx_width()  : bit width of the chunk index for a given chunk count
package seq_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // A single chunk still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_ctrl_chunk_adder.sv
// chunk_adder: W-bit ripple-carry adder with carry-in.
//   a_i, b_i : W-bit addends
//   carry_i  : carry into bit 0
//   sum_o    : W+1-bit result, MSB is the carry-out
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         carry_i,
  output logic [W:0]   sum_o
);

  logic [W-1:0] s_w;
  logic         c_w;

  always_comb begin
    c_w = carry_i;
    s_w = '0;
    for (int i = 0; i < W; i++) begin
      s_w[i] = a_i[i] ^ b_i[i] ^ c_w;
      c_w    = (a_i[i] & b_i[i]) | (c_w & (a_i[i] ^ b_i[i]));
    end
  end

  assign sum_o = {c_w, s_w};

endmodule

// File: rtl/seq_adder_ctrl.sv
// seq_adder_ctrl: adds two WIDTH-bit unsigned operands one CHUNK-bit slice
// per cycle through a single chunk_adder.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b)
//   out_valid/out_ready : result handshake (sum, WIDTH+1 bits, MSB = carry)
//   busy                : high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | adding slice idx, one slice per cycle
// DONE  | result held on sum until out_ready
module seq_adder_ctrl
  import seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam int RW     = WIDTH + 1;
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NCHUNK - 1);
  localparam logic [RW-1:0]   SLICE_MASK = RW'({CHUNK{1'b1}});

  if (CHUNK < 1) begin : g_bad_chunk
    $error("seq_adder_ctrl: CHUNK must be at least 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("seq_adder_ctrl: WIDTH must be a multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [RW-1:0]     res_q, res_d;
  logic              alive_q;

  int                off_w;
  logic [CHUNK-1:0]  a_sl_w, b_sl_w;
  logic [CHUNK:0]    add_w;

  assign off_w  = int'(idx_q) * CHUNK;
  assign a_sl_w = CHUNK'(a_q >> off_w);
  assign b_sl_w = CHUNK'(b_q >> off_w);

  chunk_adder #(.W(CHUNK)) u_chunk_adder (
    .a_i    (a_sl_w),
    .b_i    (b_sl_w),
    .carry_i(carry_q),
    .sum_o  (add_w)
  );

  // alive_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      alive_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && alive_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_d   = (res_q & ~(SLICE_MASK << off_w)) |
                  (RW'(add_w[CHUNK-1:0]) << off_w);
        carry_d = add_w[CHUNK];
        if (idx_q == IDX_LAST) begin
          res_d[WIDTH] = add_w[CHUNK];
          state_d      = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = alive_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = res_q;

endmodule

// File: tb/tb_seq_adder_ctrl.sv
module tb_seq_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] sum;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_adder_ctrl #(.WIDTH(32), .CHUNK(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation and waits for out_valid; returns the cycle count
  // from the accept edge to the edge that raised out_valid (0 on timeout).
  task automatic start_and_wait(input logic [31:0] av, input logic [31:0] bv,
                                input string tag, output int lat);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (out_valid) break;
      tick();
      if (out_valid) lat = k;
    end
    if (!out_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [32:0] exp, input string tag);
    int lat;
    start_and_wait(av, bv, tag, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(sum), 64'(exp));
    tick();
    chk({tag, "_idle"}, 64'({in_ready, out_valid, busy}), 64'b100);
  endtask

  initial begin
    int lat, bad_stable, last_acc, acc;
    logic [32:0] held, exp_s;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) tick();
    chk("rst_outs", 64'({in_ready, out_valid, busy}), 64'b000);
    chk("rst_sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Scenarios 1-3
    run_op(32'h0000_0003, 32'h0000_0004, 33'h0_0000_0007, "s1");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, "s2");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, "s3");
    run_op(32'h1234_5678, 32'h8765_4321, 33'h0_9999_9999, "s3b");

    // Scenario 4: back-pressure in DONE
    out_ready = 1'b0;
    start_and_wait(32'hA5A5_0F0F, 32'h5A5A_F0F1, "s4", lat);
    chk("s4_lat", 64'(lat), 64'd4);
    held = 33'h1_0000_0000;
    chk("s4_sum", 64'(sum), 64'(held));
    bad_stable = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      if (!out_valid || in_ready || !busy || sum !== held) bad_stable++;
    end
    chk("s4_stable_cycles_bad", 64'(bad_stable), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("s4_release_idle", 64'({in_ready, out_valid, busy}), 64'b100);
    tick();
    chk("s4_pulse_ignored", 64'(busy), 64'd0);

    // Scenario 5: reset in the second CALC cycle
    a = 32'h0000_0005;
    b = 32'h0000_0006;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("s5_rst_outs", 64'({in_ready, out_valid, busy}), 64'b000);
    tick();
    tick();
    rst_n = 1'b1;
    bad_stable = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid || busy) bad_stable++;
    end
    chk("s5_no_out_valid", 64'(bad_stable), 64'd0);
    chk("s5_sum_cleared", 64'(sum), 64'd0);
    run_op(32'h0000_0010, 32'h0000_0020, 33'h0_0000_0030, "s5_next");

    // Scenario 6: streaming with in_valid held high
    out_ready = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      b = $urandom;
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !in_ready; k++) tick();
      if (!in_ready) begin
        chk("s6_wait_ready_timeout", 64'd0, 64'd1);
        break;
      end
      exp_s = {1'b0, a} + {1'b0, b};
      tick();
      acc = cyc;
      if (i > 0) chk("s6_spacing", 64'(acc - last_acc), 64'd6);
      last_acc = acc;
      a = $urandom;
      b = $urandom;
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      if (!out_valid) begin
        chk("s6_out_valid_timeout", 64'd0, 64'd1);
        break;
      end
      chk("s6_sum", 64'(sum), 64'(exp_s));
      tick();
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
